// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the sequential binary-to-BCD converter.
//   NUM_DIGITS  : number of BCD digits produced (thousands..units)
//   MAX_VAL     : default largest displayable value, larger inputs saturate
//   BLANK_CODE  : digit code the downstream 7-segment decoder renders blank
//   bcd_digit_t : one BCD digit
//   state_t     : converter control states
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_VAL    = 9999;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble nibble adjust: adds 3 when the nibble is 5 or
// more, so the following left shift carries correctly into the next decade.
// Ports:
//   nibble   in  4  scratch nibble before the shift
//   adjusted out 4  nibble after the conditional +3 (wraps within 4 bits)
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3). A start pulse in IDLE
// captures bin_in; BIN_W shift cycles later the four digits are loaded into
// output registers together with a one-cycle done pulse. Digits hold steady
// between conversions so the display never shows partial results.
//
// Parameters:
//   BIN_W    width of bin_in
//   MAX_VAL  largest displayable value; larger inputs show 9,9,9,9 + overflow
//
// Ports:
//   clk       in   1      system clock
//   rst       in   1      asynchronous, active-high reset
//   bin_in    in   BIN_W  value to convert, sampled only on an accepted start
//   start     in   1      conversion request, accepted only in IDLE
//   busy      out  1      conversion in progress (registered, trails state)
//   done      out  1      one-cycle pulse when new digits are valid
//   overflow  out  1      last accepted value exceeded MAX_VAL
//   d3..d0    out  4 each BCD digits, thousands..units, registered
//
// Optional build macro:
//   BCD_BLANK_LEADING_ZEROS_EN  leading zero digits (never d0) load as
//                               BLANK_CODE; saturation is unaffected.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       d3,
  output logic [3:0]       d2,
  output logic [3:0]       d1,
  output logic [3:0]       d0
);

  import bcd_pkg::*;

  localparam int SCR_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_sr_q;
  logic [SCR_W-1:0] scratch_q;
  logic [SCR_W-1:0] scratch_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_over_max;
  bcd_digit_t       digit_q [NUM_DIGITS];
  bcd_digit_t       load_d  [NUM_DIGITS];

  // The top adjusted bit is shifted out; it is only ever set for inputs that
  // are saturated anyway, so its value never reaches the outputs.
  logic unused_carry;
  assign unused_carry = scratch_adj[SCR_W-1];

  assign in_over_max = ({{(32-BIN_W){1'b0}}, bin_in} > 32'(MAX_VAL));

  // Per-nibble +3 adjust; no carry crosses nibble boundaries.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble   (scratch_q[4*g +: 4]),
      .adjusted (scratch_adj[4*g +: 4])
    );
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit values loaded in DONE: saturation, then optional zero blanking
  // ---------------------------------------------------------------------------
`ifdef BCD_BLANK_LEADING_ZEROS_EN
  logic leading;
`endif

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_d[i] = ovf_q ? bcd_digit_t'(4'd9) : scratch_q[4*i +: 4];
    end
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    // Blank from the top digit down until the first nonzero; d0 always shows.
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (leading && (load_d[i] == 4'd0)) load_d[i] = BLANK_CODE;
      else                                leading   = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr_q  <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else begin
      // busy trails the state by one cycle so it brackets the done pulse.
      busy <= (state_q != IDLE);
      done <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_sr_q  <= bin_in;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            ovf_q     <= in_over_max;
          end
        end
        SHIFT: begin
          scratch_q <= {scratch_adj[SCR_W-2:0], bin_sr_q[BIN_W-1]};
          bin_sr_q  <= bin_sr_q << 1;
          cnt_q     <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          overflow <= ovf_q;
          for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= load_d[i];
        end
        default: ;
      endcase
    end
  end

  assign d3 = digit_q[3];
  assign d2 = digit_q[2];
  assign d1 = digit_q[1];
  assign d0 = digit_q[0];

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed self-checking bench for bin_to_bcd_seq with hand-computed digits.
// Expected digits depend on BCD_BLANK_LEADING_ZEROS_EN where blanking applies.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [BIN_W-1:0] bin_in = '0;
  logic             start = 1'b0;
  logic             busy, done, overflow;
  logic [3:0]       d3, d2, d1, d0;
  logic [15:0]      dig;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] prev_d   = 16'h0000;
  logic        prev_ovf = 1'b0;

  assign dig = {d3, d2, d1, d0};

  bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .d3       (d3),
    .d2       (d2),
    .d1       (d1),
    .d0       (d0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pick(input logic [15:0] plain,
                                       input logic [15:0] blanked);
`ifdef BCD_BLANK_LEADING_ZEROS_EN
    return blanked;
`else
    return plain;
`endif
  endfunction

  // One conversion: start is sampled at edge T, then observed at each falling
  // edge k = 0..20 after it. glitch re-requests with another value at k = 5.
  task automatic run_conv(input string tag, input int val,
                          input logic [15:0] exp_d, input logic exp_ovf,
                          input bit glitch);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    bin_in = val[BIN_W-1:0];
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~bin_in;   // later input changes must not matter
    check({tag, " busy_k0"}, busy, 0);
    for (int k = 1; k <= 20; k++) begin
      if (glitch && k == 5) begin bin_in = 14'd1111; start = 1'b1; end
      if (glitch && k == 6) start = 1'b0;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k == 14) begin
        check({tag, " hold_digits"}, dig, prev_d);
        check({tag, " hold_ovf"}, overflow, prev_ovf);
      end
    end
    check({tag, " busy_cycles"}, busy_n, 15);
    check({tag, " done_count"}, done_n, 1);
    check({tag, " done_at"}, done_at, 15);
    check({tag, " digits"}, dig, exp_d);
    check({tag, " ovf"}, overflow, exp_ovf);
    prev_d   = exp_d;
    prev_ovf = exp_ovf;
  endtask

  initial begin
    int done_n, first_at, second_at;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ovf", overflow, 0);
    check("rst digits", dig, 16'h0000);
    rst = 1'b0;

    // Main conversions
    run_conv("zero",  0,     pick(16'h0000, 16'hFFF0), 1'b0, 1'b0);
    run_conv("1234",  1234,  16'h1234, 1'b0, 1'b0);
    run_conv("9999",  9999,  16'h9999, 1'b0, 1'b0);
    run_conv("10000", 10000, 16'h9999, 1'b1, 1'b0);
    run_conv("16383", 16383, 16'h9999, 1'b1, 1'b0);
    run_conv("42",    42,    pick(16'h0042, 16'hFF42), 1'b0, 1'b0);
    run_conv("1005",  1005,  16'h1005, 1'b0, 1'b0);
    run_conv("5678g", 5678,  16'h5678, 1'b0, 1'b1);

    // Reset mid-conversion
    @(negedge clk);
    bin_in = 14'd4321;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort ovf", overflow, 0);
    check("abort digits", dig, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort no_done", done_n, 0);
    check("abort idle", busy, 0);
    prev_d   = 16'h0000;
    prev_ovf = 1'b0;
    run_conv("87", 87, pick(16'h0087, 16'hFF87), 1'b0, 1'b0);

    // start held high: one conversion every BIN_W+2 cycles
    @(negedge clk);
    bin_in = 14'd100;
    start  = 1'b1;
    done_n = 0; first_at = -1; second_at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (first_at < 0) first_at = k;
        else if (second_at < 0) second_at = k;
      end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("b2b done_count", done_n, 2);
    check("b2b first_at", first_at, 15);
    check("b2b period", second_at - first_at, BIN_W + 2);
    check("b2b digits", dig, pick(16'h0100, 16'hF100));
    check("b2b idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_bin_to_bcd_seq

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the 4-digit 7-segment display driver. It accepts an unsigned binary value on a start pulse and produces four registered BCD digits (d3..d0). The digits stay stable between conversions, so the display never shows intermediate values.

Parameters:
BIN_W, 14, width of the binary input; 14 bits covers 0..16383.
MAX_VAL, 9999, largest displayable value; inputs above it saturate.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset, asynchronous, active-high
bin_in  input  BIN_W  unsigned value to convert; sampled only on an accepted start
start  input  1  conversion request; accepted only in IDLE
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when new digits are valid
overflow  output  1  last accepted bin_in exceeded MAX_VAL; held until the next done
d3, d2, d1, d0  output  4 each  BCD digits, thousands..units, registered

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: d3..d0 = 0, done = 0, busy = 0, overflow = 0, state = IDLE, internal shift registers = 0.
- State machine:
  - IDLE -> SHIFT on start=1. Capture bin_in into the shift register, clear the BCD scratch register, load the bit counter with BIN_W.
  - SHIFT: each cycle, every scratch nibble >= 5 gets +3, then {scratch, bin} shifts left by 1 and the counter decrements. After BIN_W cycles, go to DONE.
  - DONE: load d3..d0 from scratch, set overflow, pulse done = 1, then go to IDLE.
- Latency: start sampled at edge T -> busy = 1 from T+1. SHIFT occupies T+1..T+BIN_W. done and new digits appear at T+BIN_W+1 (cycle 15 for BIN_W = 14). busy falls at T+BIN_W+2.
- Saturation: if the captured value > MAX_VAL, the DONE state loads digits 9,9,9,9 and sets overflow = 1. Otherwise overflow = 0.
- start while busy: ignored, with no queuing and no effect on the conversion in flight.
- start asserted in the same cycle that DONE returns to IDLE: not accepted (state is still DONE). It is accepted from the next cycle.
- start held high continuously: back-to-back conversions, one every BIN_W+2 cycles.
- Scratch register width is 4*4 = 16 bits. Add-3 is applied per nibble with no cross-nibble carry. Values <= 9999 never carry beyond d3.
- Outputs d3..d0 change only in DONE or on reset; they are never combinational from the scratch register.
- Reset mid-conversion: immediate abort to IDLE, all outputs cleared, no done pulse.
- bin_in changes after acceptance have no effect.

Optional Feature:
Macro: BCD_BLANK_LEADING_ZEROS_EN.
- Defined: in DONE, leading zero digits (from d3 downward, stopping at the first nonzero digit) are loaded as 4'hF, the blank code that the downstream decoder renders as all segments off. d0 is never blanked, so value 0 shows as F,F,F,0. Overflow saturation (9999) is unaffected.
- Undefined: plain BCD digits with zero padding.

Decomposition:
- Package bcd_pkg holds:
  - NUM_DIGITS = 4
  - MAX_VAL default 9999
  - BLANK_CODE = 4'hF
  - typedef bcd_digit_t (logic [3:0])
  - typedef enum state_t {IDLE, SHIFT, DONE}
- Sub-module bcd_add3: combinational single-nibble adjust (in >= 5 ? in + 3 : in). It is instantiated NUM_DIGITS times inside the SHIFT datapath.

Test Plan:
1. Reset, then bin_in = 0, start pulse -> done at cycle T+15; d3..d0 = 0,0,0,0; overflow = 0; busy high for exactly 15 cycles.
2. bin_in = 1234, start -> d = 1,2,3,4. Then bin_in = 9999 -> d = 9,9,9,9 with overflow = 0. d holds 1,2,3,4 until the second done.
3. bin_in = 10000, then 16383 -> d = 9,9,9,9, overflow = 1. Next conversion of 42 -> d = 0,0,4,2, overflow cleared at that done.
4. Start 5678, change bin_in to 1111 and pulse start at T+5 -> result 5,6,7,8 and exactly one done pulse.
5. Start 4321, assert rst at T+7 for 1 cycle -> d = 0, busy = 0, no done. A following start of 87 -> 0,0,8,7.
6. With BCD_BLANK_LEADING_ZEROS_EN: 42 -> F,F,4,2; 0 -> F,F,F,0; 1005 -> 1,0,0,5. Without the macro, 42 -> 0,0,4,2.
